// File: rtl/jk_cmd_driver_if.sv
// Command handshake bundle for jk_cmd_driver: a valid/ready offer of {op,len}.
interface jk_cmd_driver_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_len;

  modport master (output cmd_valid, output cmd_op, output cmd_len, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_len, output cmd_ready);
endinterface

// File: rtl/jk_cmd_driver.sv
// Queues {J,K} drive commands, drives a downstream master-slave JK pair for len+1
// cycles, lets it settle for two cycles, then checks its slave Q against a local model.
module jk_cmd_driver (
  input  logic             clk,
  input  logic             clear,
  jk_cmd_driver_if.slave   cmd,
  output logic             Set,
  output logic             Reset,
  input  logic             qs_in,
  output logic             exp_q,
  output logic             busy,
  output logic             done,
  output logic             mismatch
);

  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE1, SETTLE2} state_t;

  state_t     state;
  logic [5:0] mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;
  logic [1:0] op;
  logic [3:0] counter;
  logic       full;
  logic       push;
  logic       pop;

  // Ready reflects the pre-pop occupancy, so a full FIFO never accepts even while popping.
  assign full          = (count == 3'd4);
  assign cmd.cmd_ready = ~full;
  assign push          = cmd.cmd_valid & ~full;
  assign pop           = (state == IDLE) & (count != 3'd0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd.cmd_op, cmd.cmd_len};
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b00, push} - {2'b00, pop};
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state    <= IDLE;
      op       <= 2'b00;
      counter  <= 4'd0;
      Set      <= 1'b0;
      Reset    <= 1'b0;
      exp_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          Set   <= 1'b0;
          Reset <= 1'b0;
          if (pop) begin
            {op, counter} <= mem[rd_ptr];
            busy          <= 1'b1;
            state         <= DRIVE;
          end
        end
        DRIVE: begin
          // Outputs and model advance together; the pair sees each drive one edge later.
          Set   <= op[1];
          Reset <= op[0];
          case (op)
            2'b01:   exp_q <= 1'b0;
            2'b10:   exp_q <= 1'b1;
            2'b11:   exp_q <= ~exp_q;
            default: exp_q <= exp_q;
          endcase
          counter <= counter - 4'd1;
          if (counter == 4'd0) begin
            state <= SETTLE1;
          end
        end
        SETTLE1: begin
          Set   <= 1'b0;
          Reset <= 1'b0;
          state <= SETTLE2;
        end
        SETTLE2: begin
          if (qs_in != exp_q) begin
            mismatch <= 1'b1;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/jk_cmd_driver.md
JK_CMD_DRIVER -- requirements
Module: jk_cmd_driver

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state updates on posedge.
REQ-002 SHALL have port: clear  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: cmd_valid  in  1  command offered.
REQ-004 SHALL have port: cmd_ready  out  1  command FIFO can accept.
REQ-005 SHALL have port: cmd_op  in  2  {J,K} code: 00 hold, 01 reset, 10 set, 11 toggle.
REQ-006 SHALL have port: cmd_len  in  4  drive duration minus one (1-16 cycles).
REQ-007 SHALL have port: Set  out  1  registered J drive to downstream master-slave JK pair.
REQ-008 SHALL have port: Reset  out  1  registered K drive to downstream master-slave JK pair.
REQ-009 SHALL have port: qs_in  in  1  slave Q returned from the JK pair.
REQ-010 SHALL have port: exp_q  out  1  modelled expected slave Q.
REQ-011 SHALL have port: busy  out  1  high in DRIVE or SETTLE.
REQ-012 SHALL have port: done  out  1  one-cycle pulse at command completion.
REQ-013 SHALL have port: mismatch  out  1  sticky compare-failure flag.

Function
REQ-014 SHALL hold commands {op,len} in a 4-entry FIFO; cmd_ready = not full; push on cmd_valid && cmd_ready.
REQ-015 SHALL ignore cmd_valid while full; no entry lost or overwritten.
REQ-016 SHALL allow push and pop in the same cycle; count unchanged; push into full FIFO only if a pop occurs that cycle is NOT permitted (ready reflects pre-pop state).
REQ-017 SHALL implement FSM states IDLE, DRIVE, SETTLE1, SETTLE2.
REQ-018 IDLE: if FIFO non-empty, pop head, load op and counter=len, go DRIVE; else stay, Set=Reset=0.
REQ-019 DRIVE: Set=op[1], Reset=op[0] every cycle; counter decrements; at counter=0 transition to SETTLE1 after that cycle; total drive cycles = len+1.
REQ-020 DRIVE: exp_q updates once per drive cycle: 00 keep, 01 -> 0, 10 -> 1, 11 -> invert.
REQ-021 SETTLE1, SETTLE2: Set=Reset=0; exp_q held.
REQ-022 At the edge leaving SETTLE2, SHALL compare qs_in with exp_q; inequality sets mismatch, which stays high until clear.
REQ-023 SHALL pulse done for exactly the one cycle following the SETTLE2 edge, then IDLE; next command pops no earlier than that IDLE cycle (one idle cycle between commands).
REQ-024 Latency: command pushed into empty FIFO while IDLE -> Set/Reset asserted 2 cycles after push edge.
REQ-025 busy SHALL be high exactly in DRIVE, SETTLE1, SETTLE2.
REQ-026 cmd_len=0 SHALL give a single drive cycle; op 00 SHALL still traverse DRIVE/SETTLE and compare.
REQ-027 exp_q SHALL track the slave Q of a downstream pair sharing clk and clear; 2-cycle settle covers master posedge plus slave negedge.

Reset
REQ-028 clear high SHALL immediately force: FIFO empty, state IDLE, counter 0, Set=0, Reset=0, exp_q=0, busy=0, done=0, mismatch=0, cmd_ready=1.
REQ-029 clear asserted mid-DRIVE or mid-SETTLE SHALL abort the command with no done pulse and no compare.
REQ-030 After clear deasserts, first push SHALL be accepted on the next posedge.

Verification
REQ-031 After clear, push {10,len=2}, pair connected -> Set=1 for 3 cycles, done pulse once, exp_q=1, qs_in=1, mismatch=0.
REQ-032 Push {11,0},{11,0},{11,1} back-to-back -> exp_q 1, 0, 0 after each done; three done pulses each followed by one IDLE cycle; mismatch=0.
REQ-033 Push 6 commands while busy with cmd_valid held -> cmd_ready low after 4 queued, no loss, all 6 execute in order.
REQ-034 qs_in tied 0, push {10,0} -> mismatch=1 after done, stays 1 through later passing commands until clear.
REQ-035 clear pulsed during DRIVE of {10,5} -> all outputs at reset values at once, no done, queued commands discarded.
REQ-036 Push while full concurrent with pop -> push rejected (cmd_ready=0), FIFO count decrements by one.
